// File: rtl/store_align_queue.sv
// Store alignment queue.
// Accepts SB/SH/SW requests from the MEM stage, rejects misaligned or
// reserved-type stores with a one-cycle fault pulse, replicates store data
// into byte lanes with a matching write strobe, and buffers aligned stores
// in a small FIFO that drains to the data-memory write port over valid/ready.
module store_align_queue #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [1:0]       req_type,
    input  logic [31:0]      req_data,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    output logic             misalign,
    output logic [31:0]      misalign_addr,
    output logic             busy,
    output logic [CNT_W-1:0] store_cnt
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_QW = PTR_W + 1;
    localparam logic [CNT_QW-1:0] DEPTH_C = CNT_QW'(DEPTH);

    // A store faults when its address is not naturally aligned for its size,
    // or when the size encoding is the reserved value.
    function automatic logic store_fault(input logic [1:0] typ, input logic [1:0] lo);
        logic f;
        case (typ)
            2'b00:   f = 1'b0;
            2'b01:   f = lo[0];
            2'b10:   f = (lo != 2'b00);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

    // Replicate the right-justified store data across every lane it could land in.
    function automatic logic [31:0] lane_wdata(input logic [1:0] typ, input logic [31:0] data);
        logic [31:0] w;
        case (typ)
            2'b00:   w = {4{data[7:0]}};
            2'b01:   w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

    // Byte enables selecting the lanes actually written.
    function automatic logic [3:0] lane_wstrb(input logic [1:0] typ, input logic [1:0] lo);
        logic [3:0] s;
        case (typ)
            2'b00:   s = 4'b0001 << lo;
            2'b01:   s = lo[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Queue storage
    logic [31:0]       addr_q [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [3:0]        strb_q [DEPTH];

    // Control state and next-state
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_QW-1:0] count_q, count_d;
    logic [CNT_W-1:0]  store_cnt_q, store_cnt_d;
    logic              misalign_q, misalign_d;
    logic [31:0]       misalign_addr_q, misalign_addr_d;

    // Request-side decode
    logic              accept_s;
    logic              fault_s;
    logic              push_s;
    logic              pop_s;
    logic              not_empty_s;
    logic [31:0]       entry_addr_s;
    logic [31:0]       entry_data_s;
    logic [3:0]        entry_strb_s;

    // Decode the handshakes and compute the next control state.
    always_comb begin
        not_empty_s     = (count_q != {CNT_QW{1'b0}});
        accept_s        = req_valid && (count_q < DEPTH_C);
        fault_s         = store_fault(req_type, req_addr[1:0]);
        push_s          = accept_s && !fault_s;
        pop_s           = not_empty_s && mem_ready;
        entry_addr_s    = {req_addr[31:2], 2'b00};
        entry_data_s    = lane_wdata(req_type, req_data);
        entry_strb_s    = lane_wstrb(req_type, req_addr[1:0]);

        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        store_cnt_d     = store_cnt_q;
        misalign_d      = accept_s && fault_s;
        misalign_addr_d = misalign_addr_q;

        if (push_s) begin
            tail_d = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end

        if (pop_s) begin
            head_d      = head_q + PTR_W'(1);
            store_cnt_d = store_cnt_q + CNT_W'(1);
        end else begin
            head_d      = head_q;
            store_cnt_d = store_cnt_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_QW'(1);
            2'b01:   count_d = count_q - CNT_QW'(1);
            default: count_d = count_q;
        endcase

        if (accept_s && fault_s) begin
            misalign_addr_d = req_addr;
        end else begin
            misalign_addr_d = misalign_addr_q;
        end
    end

    // Control registers; reset discards queued stores and any pending fault pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            store_cnt_q     <= '0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= 32'h0000_0000;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            store_cnt_q     <= store_cnt_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    // Entry storage; the tail never aliases a live head, so a stalled head beat stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 32'h0000_0000;
                data_q[i] <= 32'h0000_0000;
                strb_q[i] <= 4'b0000;
            end
        end else if (push_s) begin
            addr_q[tail_q] <= entry_addr_s;
            data_q[tail_q] <= entry_data_s;
            strb_q[tail_q] <= entry_strb_s;
        end
    end

    assign req_ready     = (count_q < DEPTH_C);
    assign mem_valid     = not_empty_s;
    assign busy          = not_empty_s;
    assign mem_addr      = addr_q[head_q];
    assign mem_wdata     = data_q[head_q];
    assign mem_wstrb     = strb_q[head_q];
    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;
    assign store_cnt     = store_cnt_q;

endmodule

// File: doc/store_align_queue.md
Name: store_align_queue

Overview:
- Store-side counterpart of the load write-back alignment logic.
- Takes SB/SH/SW requests from the MEM stage, checks alignment, and replicates data into byte lanes with a write strobe.
- Queues aligned stores in a small FIFO and drives them to the data-memory write port over a valid/ready handshake.
- Sits between the MEM-stage store path and the DM/bus write interface.

Parameters:
- DEPTH, 2: store-queue entries (power of 2, ≥2).
- CNT_W, 16: width of the completed-store counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  store request present.
- req_ready  output  1  block accepts a request this cycle.
- req_addr  input  32  byte address of the store.
- req_type  input  2  00=SB, 01=SH, 10=SW, 11=reserved.
- req_data  input  32  store data, right-justified.
- mem_valid  output  1  write beat valid.
- mem_ready  input  1  memory accepts the beat.
- mem_addr  output  32  word address, bits [1:0] forced to 00.
- mem_wdata  output  32  lane-replicated write data.
- mem_wstrb  output  4  byte write enables, active-high, bit i = byte i.
- misalign  output  1  one-cycle pulse: the accepted request was misaligned or reserved.
- misalign_addr  output  32  address of the faulting request; valid while misalign=1.
- busy  output  1  queue non-empty.
- store_cnt  output  CNT_W  number of completed memory write beats.

Behaviour:
- Clock and reset: one clock, clk; synchronous active-high rst.
- Reset values:
  - Queue empty; mem_valid=0, busy=0.
  - misalign=0, misalign_addr=0, store_cnt=0.
  - mem_addr, mem_wdata and mem_wstrb=0.
  - req_ready=1 in the cycle after reset deasserts.
- Accept: req_ready = (count < DEPTH), combinational from the count register only. There is no bypass: when the queue is full, req_ready=0 even if a pop occurs in the same cycle.
- Request is accepted on a clk edge where req_valid && req_ready.
- Alignment check on accept:
  - SB: always aligned.
  - SH: misaligned if addr[0]=1.
  - SW: misaligned if addr[1:0]≠00.
  - type 11: always faulting.
- Faulting accept: not enqueued. Next cycle misalign=1 and misalign_addr=req_addr for exactly one cycle. Back-to-back faults give consecutive pulses.
- Aligned accept: an entry {addr[31:2],00; wdata; wstrb} is written at the tail.
- Lane rules:
  - SB: wdata={4{data[7:0]}}; wstrb=0001<<addr[1:0].
  - SH: wdata={2{data[15:0]}}; wstrb=addr[1]?1100:0011.
  - SW: wdata=data; wstrb=1111.
- Output:
  - mem_valid = (count≠0).
  - mem_addr, mem_wdata and mem_wstrb come from the head entry, driven from registers.
  - Latency from accept edge to mem_valid is one cycle when the queue was empty.
- Handshake:
  - Pop on a clk edge with mem_valid && mem_ready.
  - While mem_valid && !mem_ready, all mem_* outputs hold stable.
  - mem_valid never deasserts without a pop.
- Simultaneous push and pop when not full: count unchanged, order preserved (FIFO).
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- store_cnt increments by 1 per pop and wraps at 2^CNT_W to 0.
- busy = (count≠0).
- rst asserted mid-operation: all queued entries are discarded, any pending misalign pulse is cancelled, and store_cnt clears. No partial beat is held.
- mem_ready while mem_valid=0 is ignored.

Test Plan:
- SB to each lane:
  - Stimulus: addr 0x100..0x103, data 0x000000A5, mem_ready=1.
  - Required: four beats at mem_addr 0x100, wdata 0xA5A5A5A5, wstrb 0001, 0010, 0100, 1000.
  - Required: each beat's mem_valid comes one cycle after its accept; store_cnt=4.
- SH/SW:
  - Stimulus: SH addr 0x202 data 0x1234BEEF, then SW addr 0x204 data 0xCAFEF00D.
  - Required: beat 1 = 0x200, wdata 0xBEEFBEEF, wstrb 1100.
  - Required: beat 2 = 0x204, wdata 0xCAFEF00D, wstrb 1111.
- Misalign:
  - Stimulus: SW addr 0x301, then SH addr 0x305, then type 11 addr 0x308.
  - Required: req_ready stays 1; three consecutive misalign pulses with addr 0x301, 0x305, 0x308.
  - Required: no mem_valid; store_cnt=0.
- Backpressure/full:
  - Stimulus: mem_ready=0 and 3 SW requests.
  - Required: first two accepted, then req_ready=0; the head beat is held stable.
  - Stimulus: raise mem_ready for 1 cycle.
  - Required: the pop occurs; req_ready=1 next cycle; the third request is accepted; order is preserved.
- Simultaneous push/pop:
  - Stimulus: count=1, accept a new SW in the same cycle the head pops.
  - Required: count stays 1; the next beat is the new store.
- Reset mid-op:
  - Stimulus: queue full with mem_ready=0, assert rst for 1 cycle.
  - Required: next cycle mem_valid=0, busy=0, store_cnt=0, req_ready=1.
